// File: rtl/trace_pkg.sv
// Shared types and helpers for the cache access trace recorder.
//   TRACE_ADDR_W : address / delta width used by the record type
//   trace_rec_t  : one buffered trace record {signed delta, hit}
//   enc_delta()  : modular address difference used for delta encoding
package trace_pkg;

    localparam int unsigned TRACE_ADDR_W = 32;

    typedef struct packed {
        logic signed [TRACE_ADDR_W-1:0] delta;
        logic                           hit;
    } trace_rec_t;

    // Two's complement wrap is intended; the replay side adds the delta back modulo 2^W.
    function automatic logic [TRACE_ADDR_W-1:0] enc_delta(
        input logic [TRACE_ADDR_W-1:0] addr,
        input logic [TRACE_ADDR_W-1:0] prev
    );
        return addr - prev;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO of trace records.
//   clk, rst : clock and synchronous active-high reset (empties the FIFO)
//   push, din: write request and record; ignored when full unless a pop happens too
//   pop      : read request; ignored while empty
//   dout     : head record, forced to zero while empty
//   full, empty, count : occupancy status
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned Depth = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  trace_rec_t             din,
    output trace_rec_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(Depth):0] count
);

    localparam int unsigned IdxW = $clog2(Depth);

    logic [IdxW:0] wr_ptr_q, wr_ptr_d;
    logic [IdxW:0] rd_ptr_q, rd_ptr_d;
    trace_rec_t    mem_q [Depth];
    logic          do_push;
    logic          do_pop;

    // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                   (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: dout is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[IdxW-1:0]] <= din;
    end

    assign dout = empty ? '0 : mem_q[rd_ptr_q[IdxW-1:0]];

endmodule

// File: rtl/cache_trace_recorder.sv
// Records the cache access stream as signed address deltas and streams them out.
//   clk, rst             : clock and synchronous active-high reset
//   rec_en               : capture enable; when low nothing is captured or counted
//   addr, hit, miss      : cache access observed this cycle
//   out_valid/out_ready  : record stream handshake
//   out_delta, out_hit   : head record (delta vs. previous enqueued address, outcome)
//   recorded, dropped    : wrapping counts of enqueued / full-FIFO-lost accesses
//   proto_err            : sticky, hit and miss seen together on a captured access
// ADDR_W must equal trace_pkg::TRACE_ADDR_W since the record type is fixed there.
module cache_trace_recorder
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W     = TRACE_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic              hit,
    input  logic              miss,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_delta,
    output logic              out_hit,
    output logic [CNT_W-1:0]  recorded,
    output logic [CNT_W-1:0]  dropped,
    output logic              proto_err
);

    localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
    localparam logic [IdxW:0] DepthCnt = (IdxW + 1)'(FIFO_DEPTH);

    logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
    logic [CNT_W-1:0]  recorded_q, recorded_d;
    logic [CNT_W-1:0]  dropped_q, dropped_d;
    logic              proto_err_q, proto_err_d;

    logic              event_v;
    logic              pop;
    logic              room;
    logic              accept;
    trace_rec_t        rec;
    trace_rec_t        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [IdxW:0]     fifo_count;

    assign event_v = rec_en & (hit | miss);
    assign pop     = ~fifo_empty & out_ready;
    // Space exists below the depth limit, or at the limit when the head pops this edge.
    assign room    = (~fifo_full & (fifo_count < DepthCnt)) | pop;
    assign accept  = event_v & room;

    // A simultaneous hit+miss is logged as a miss.
    assign rec.delta = enc_delta(addr, prev_addr_q);
    assign rec.hit   = hit & ~miss;

    always_comb begin
        prev_addr_d = prev_addr_q;
        recorded_d  = recorded_q;
        dropped_d   = dropped_q;
        proto_err_d = proto_err_q;
        if (accept) begin
            prev_addr_d = addr;
            recorded_d  = recorded_q + CNT_W'(1);
        end else if (event_v) begin
            dropped_d = dropped_q + CNT_W'(1);
        end
        if (event_v & hit & miss) proto_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_addr_q <= '0;
            recorded_q  <= '0;
            dropped_q   <= '0;
            proto_err_q <= 1'b0;
        end else begin
            prev_addr_q <= prev_addr_d;
            recorded_q  <= recorded_d;
            dropped_q   <= dropped_d;
            proto_err_q <= proto_err_d;
        end
    end

    trace_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (pop),
        .din   (rec),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign out_delta = fifo_dout.delta;
    assign out_hit   = fifo_dout.hit;
    assign recorded  = recorded_q;
    assign dropped   = dropped_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_cache_trace_recorder.sv
// Bench for cache_trace_recorder: directed test-plan scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_cache_trace_recorder;

    localparam int AW = 32;
    localparam int D  = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst, rec_en, hit, miss, out_ready;
    logic [AW-1:0] addr;
    logic          out_valid, out_hit, proto_err;
    logic [AW-1:0] out_delta;
    logic [CW-1:0] recorded, dropped;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [AW-1:0] d;
        logic          h;
    } mrec_t;

    mrec_t         mq[$];
    logic [AW-1:0] m_prev;
    logic [CW-1:0] m_rec, m_drop;
    bit            m_perr;

    cache_trace_recorder #(
        .ADDR_W     (AW),
        .FIFO_DEPTH (D),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rec_en    (rec_en),
        .addr      (addr),
        .hit       (hit),
        .miss      (miss),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_delta (out_delta),
        .out_hit   (out_hit),
        .recorded  (recorded),
        .dropped   (dropped),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("valid", 64'(out_valid), 64'(mq.size() > 0));
        chk("delta", 64'(out_delta), (mq.size() > 0) ? 64'(mq[0].d) : 64'd0);
        chk("hit", 64'(out_hit), (mq.size() > 0) ? 64'(mq[0].h) : 64'd0);
        chk("recorded", 64'(recorded), 64'(m_rec));
        chk("dropped", 64'(dropped), 64'(m_drop));
        chk("proto_err", 64'(proto_err), 64'(m_perr));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic tick(input bit r, input bit en, input bit h, input bit m, input bit rdy,
                        input logic [AW-1:0] a);
        bit    pop_e, ev, room;
        mrec_t tmp;
        rst = r; rec_en = en; hit = h; miss = m; out_ready = rdy; addr = a;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_prev = '0; m_rec = '0; m_drop = '0; m_perr = 1'b0;
        end else begin
            pop_e = rdy && (mq.size() > 0);
            ev    = en && (h || m);
            room  = (mq.size() < D) || pop_e;
            if (pop_e) tmp = mq.pop_front();
            if (ev && h && m) m_perr = 1'b1;
            if (ev && room) begin
                tmp.d = a - m_prev;
                tmp.h = h && !m;
                mq.push_back(tmp);
                m_prev = a;
                m_rec++;
            end else if (ev) begin
                m_drop++;
            end
        end
        #1;
        check_model();
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 1'b1, 1'b0, 1'b0, rdy, 32'hDEAD_BEEF);
    endtask

    logic [AW-1:0] bw_exp_d [4];
    logic          bw_exp_h [4];

    initial begin
        rst = 1'b1; rec_en = 1'b0; hit = 1'b0; miss = 1'b0; out_ready = 1'b0; addr = '0;
        mq.delete();
        m_prev = '0; m_rec = '0; m_drop = '0; m_perr = 1'b0;

        // Reset state
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h55);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_recorded", 64'(recorded), 64'd0);

        // Sequential misses with the consumer always ready
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100);
        chk("seq_first_abs", 64'(out_delta), 64'h100);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h120);
        chk("seq_second", 64'(out_delta), 64'h20);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h140);
        chk("seq_third", 64'(out_delta), 64'h20);
        chk("seq_recorded", 64'(recorded), 64'd3);
        idle(1'b1);
        chk("seq_drained", 64'(out_valid), 64'd0);

        // Backward step and wrap-around, held then drained
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10);
        bw_exp_d = '{32'h40, 32'hFFFF_FFE0, 32'hFFFF_FFD0, 32'h20};
        bw_exp_h = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            chk("bw_delta", 64'(out_delta), 64'(bw_exp_d[i]));
            chk("bw_hit", 64'(out_hit), 64'(bw_exp_h[i]));
            idle(1'b1);
        end

        // Overflow: 20 misses into a 16-deep FIFO with the consumer stalled
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 20; k++) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(k * 32'h20));
        chk("ovf_recorded", 64'(recorded), 64'd16);
        chk("ovf_dropped", 64'(dropped), 64'd4);
        chk("ovf_head_stable", 64'(out_delta), 64'h0);
        // Full FIFO, pop and push on the same edge
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
        chk("fullpop_recorded", 64'(recorded), 64'd17);
        chk("fullpop_dropped", 64'(dropped), 64'd4);
        for (int k = 0; k < 15; k++) idle(1'b1);
        chk("ovf_17th", 64'(out_delta), 64'h220);
        idle(1'b1);
        chk("ovf_empty", 64'(out_valid), 64'd0);

        // Protocol error
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h80);
        chk("perr_flag", 64'(proto_err), 64'd1);
        chk("perr_delta", 64'(out_delta), 64'h80);
        chk("perr_as_miss", 64'(out_hit), 64'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h90);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0);
        chk("perr_sticky", 64'(proto_err), 64'd1);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("perr_cleared", 64'(proto_err), 64'd0);

        // rec_en low: no capture, no counting
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h777);
        chk("en_off_recorded", 64'(recorded), 64'd0);

        // Reset mid-stream
        for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, AW'(32'h1000 + k * 4));
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_recorded", 64'(recorded), 64'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300);
        chk("mid_rst_abs", 64'(out_delta), 64'h300);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            automatic bit            r   = ($urandom_range(0, 299) == 0);
            automatic bit            en  = ($urandom_range(0, 9) != 0);
            automatic int unsigned   sel = $urandom_range(0, 19);
            automatic bit            h   = (sel < 6) || (sel == 19);
            automatic bit            m   = ((sel >= 6) && (sel < 12)) || (sel == 19);
            automatic bit            rdy = ($urandom_range(0, 2) != 0) ^ (n[9]);
            automatic logic [AW-1:0] a   = ($urandom_range(0, 1) != 0) ?
                                           AW'($urandom()) : m_prev + AW'($urandom_range(0, 64));
            tick(r, en, h, m, rdy, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_trace_recorder.md
Name: cache_trace_recorder

Overview:
- Captures the cache access stream (address plus hit/miss outcome) beside configurable_cache.
- Delta-encodes each access against the previous recorded address and buffers the records in a FIFO.
- Streams the records out over a valid/ready interface.
- The output format is the signed-delta trace that the cache benches replay: first record is the absolute address (delta from 0), and each later address is the previous address plus the delta.

Parameters:
- ADDR_W, 32, address and delta width.
- FIFO_DEPTH, 16, record buffer entries; power of two, at least 2.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rec_en  input  1  capture enable; 0 means no capture and prev_addr is held.
- addr  input  ADDR_W  cache access address, sampled with hit/miss.
- hit  input  1  cache hit for addr this cycle.
- miss  input  1  cache miss for addr this cycle.
- out_valid  output  1  record available.
- out_ready  input  1  consumer accepts record.
- out_delta  output  ADDR_W  signed delta of the record.
- out_hit  output  1  outcome of the record: 1 = hit, 0 = miss.
- recorded  output  CNT_W  records enqueued since reset.
- dropped  output  CNT_W  accesses lost to a full FIFO.
- proto_err  output  1  sticky flag: hit and miss were asserted in the same cycle.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - FIFO emptied; out_valid=0; out_delta=0; out_hit=0.
  - recorded=0; dropped=0; proto_err=0; prev_addr=0.
  - Applies mid-stream: entries in flight are discarded, and the first access after reset is encoded absolute.
- Capture event: rec_en & (hit | miss) at a rising edge.
  - hit=1 & miss=1: proto_err is set (sticky until reset), and the access is recorded as a miss (out_hit=0).
  - hit=0 & miss=0: no event, regardless of addr.
- Encoding:
  - delta = addr - prev_addr, modulo 2^ADDR_W (two's complement wrap, no saturation).
  - prev_addr <= addr only when the record is actually enqueued.
  - A dropped access therefore does not break decodability: the next delta is relative to the last enqueued address.
- FIFO:
  - Synchronous, first-word-fall-through.
  - A record captured at edge N is visible on out_valid/out_delta/out_hit after edge N (1-cycle latency from an empty FIFO).
  - Pop occurs on out_valid & out_ready at the edge.
  - out_delta and out_hit hold stable while out_valid=1 & out_ready=0.
- Full boundary:
  - Push is accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs on the same edge.
  - Otherwise the event is dropped: dropped += 1, recorded unchanged, prev_addr unchanged.
- Empty boundary: out_ready is ignored while out_valid=0; there is no bypass path from the capture inputs to the outputs.
- Counters: recorded and dropped wrap modulo 2^CNT_W.
- rec_en=0: no capture and no counting; the output drain continues normally.
- Pointers: read/write pointers are log2(FIFO_DEPTH)+1 bits; full and empty are decided by the MSB compare.

Decomposition:
- trace_pkg holds:
  - ADDR_W default constant.
  - trace_rec_t struct: {logic signed [ADDR_W-1:0] delta; logic hit;}.
  - Function enc_delta(addr, prev).
- One sub-module, trace_fifo, is natural:
  - Generic synchronous FWFT FIFO of trace_rec_t, FIFO_DEPTH entries.
  - Ports: push, pop, din, dout, full, empty, count.
- The top level holds:
  - Capture/encode logic.
  - prev_addr register.
  - Counters and proto_err.

Test Plan:
- Sequential misses: addr 0x100, 0x120, 0x140 with miss=1, out_ready=1 -> records (0x100,0), (0x20,0), (0x20,0); recorded=3.
- Backward and wrap-around: addr 0x40 then 0x20 (hit) then 0xFFFFFFF0 then 0x10 -> deltas 0x40, -0x20 (0xFFFFFFE0), 0xFFFFFFD0, 0x20; out_hit=0,1,0,0 as driven.
- Overflow: out_ready=0 and 20 miss events at addr k*0x20, k=0..19, with FIFO_DEPTH=16 -> recorded=16, dropped=4.
  - Then assert out_ready=1 and drive event addr 0x400 -> 16 records drain, then a 17th record with delta 0x400-0x1E0=0x220.
- Full with simultaneous pop: FIFO full, out_ready=1 and an event on the same edge -> push accepted, dropped unchanged, count stays 16.
- Protocol error: hit=1 & miss=1 at addr 0x80 -> record (0x80,0), proto_err=1.
  - proto_err stays 1 through later clean accesses and clears only on rst.
- Reset mid-stream: 5 records buffered, rst=1 for one cycle -> out_valid=0, recorded=0.
  - Next event at addr 0x300 -> delta 0x300 (absolute).
